// File: rtl/text_buffer_if.sv
// Host byte-stream handshake into the text buffer: valid/ready with an 8-bit payload.
interface text_buffer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/text_buffer_ctrl.sv
// Writable character buffer for the VGA text renderer. Host writes land only during
// blanking; form feed runs a blank-gated clear sweep across every cell.
module text_buffer_ctrl #(
    parameter int          N    = 32,
    parameter logic [7:0]  FILL = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blank,
    text_buffer_if.slave      host,
    input  logic [4:0]        rd_col,
    output logic [7:0]        rd_char,
    output logic [4:0]        cursor,
    output logic              busy
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [4:0] LAST = 5'(N - 1);

    state_t     state_q, state_d;
    logic [4:0] cursor_q, cursor_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic [7:0] buf_q [N];

    logic       accept;
    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;

    assign host.in_ready = (state_q == IDLE) & blank;
    assign accept        = host.in_valid & host.in_ready;
    assign busy          = (state_q == CLEAR);
    assign cursor        = cursor_q;

    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        clr_idx_d = clr_idx_q;
        wr_en     = 1'b0;
        wr_idx    = cursor_q;
        wr_data   = FILL;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (host.in_data >= 8'h20 && host.in_data <= 8'h7F) begin
                        wr_en    = 1'b1;
                        wr_data  = host.in_data;
                        cursor_d = (cursor_q == LAST) ? 5'd0 : cursor_q + 5'd1;
                    end else if (host.in_data == 8'h0D) begin
                        cursor_d = 5'd0;
                    end else if (host.in_data == 8'h08) begin
                        // Backspace erases the cell it steps back onto.
                        cursor_d = (cursor_q == 5'd0) ? LAST : cursor_q - 5'd1;
                        wr_en    = 1'b1;
                        wr_idx   = cursor_d;
                    end else if (host.in_data == 8'h0C) begin
                        cursor_d  = 5'd0;
                        clr_idx_d = 5'd0;
                        state_d   = CLEAR;
                    end
                end
            end
            CLEAR: begin
                if (blank) begin
                    wr_en  = 1'b1;
                    wr_idx = clr_idx_q;
                    if (clr_idx_q == LAST) begin
                        clr_idx_d = 5'd0;
                        state_d   = IDLE;
                    end else begin
                        clr_idx_d = clr_idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cursor_q  <= 5'd0;
            clr_idx_q <= 5'd0;
            for (int i = 0; i < N; i++) buf_q[i] <= FILL;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            clr_idx_q <= clr_idx_d;
            for (int i = 0; i < N; i++)
                if (wr_en && wr_idx == 5'(i)) buf_q[i] <= wr_data;
        end
    end

    // Columns past the buffer read back as the fill code.
    always_comb begin
        rd_char = FILL;
        for (int i = 0; i < N; i++)
            if (rd_col == 5'(i)) rd_char = buf_q[i];
    end
endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Owns the character buffer that feeds the VGA text renderer: N character cells of 8-bit codes, read combinationally by column index.
- Replaces the fixed compile-time string with a writable buffer.
- Accepts a byte stream from a host via valid/ready, with cursor auto-advance and control codes.
- Commits writes only during blanking, so the scanned-out line never tears, and runs a sequenced clear.

Parameters:
- N, 32, number of character cells; 2 <= N <= 32.
- FILL, 8'h20, fill/reset character code (space).

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- blank  input  1  high when video is inactive (inverse of display_on)
- in_valid  input  1  host byte valid
- in_data  input  8  host byte
- in_ready  output  1  byte accepted this cycle when in_valid and in_ready are both high
- rd_col  input  5  column index from the renderer (pix_x/5, low 5 bits)
- rd_char  output  8  character code at rd_col
- cursor  output  5  current write column
- busy  output  1  clear sequence in progress

Behaviour:
- Reset is asynchronous and active-low. All N cells are set to FILL; cursor=0; state=IDLE; clr_idx=0. After reset: in_ready=0 when blank=0 (in_ready is combinational), busy=0, rd_char=FILL.
- State machine:
  - IDLE -> CLEAR on an accepted 8'h0C.
  - CLEAR -> IDLE once the cell at clr_idx==N-1 is written.
- in_ready = (state==IDLE) & blank. It is purely combinational, with no registered delay.
- On an accepted byte b:
  - 8'h20..8'h7F: buf[cursor] <= b; cursor <= (cursor==N-1) ? 0 : cursor+1.
  - 8'h0D (CR): cursor <= 0; no cell written.
  - 8'h08 (BS): cursor <= (cursor==0) ? N-1 : cursor-1; the new cursor cell is written with FILL in the same cycle.
  - 8'h0C (FF): cursor <= 0; clr_idx <= 0; state <= CLEAR.
  - Any other code (0x00-0x1F other than the above, 0x80-0xFF): consumed, no effect.
- CLEAR:
  - busy=1 and in_ready=0.
  - Each cycle with blank=1: buf[clr_idx] <= FILL; clr_idx increments.
  - Cycles with blank=0 pause; clr_idx holds.
  - Completes in exactly N blank cycles. busy drops in the cycle after the last write.
- Read path:
  - rd_char = buf[rd_col] combinationally. A write is visible on rd_char the cycle after acceptance.
  - rd_col >= N returns FILL.
- Simultaneous events:
  - Read and write of the same cell in one cycle: rd_char shows the old value.
  - blank falling in the same cycle as in_valid: no transfer, because in_ready is already low.
- Async reset mid-CLEAR or mid-transfer: everything returns to reset values immediately. A partially cleared buffer becomes all FILL.
- Glyph range: only 0x20..0x7F are stored, so downstream c = code-32 is always within 0..95.

Test Plan:
- Reset with blank=1 -> rd_char=8'h20 for all rd_col 0..31; cursor=0; busy=0; in_ready=1.
- Blank=1, send "AB" (8'h41, 8'h42) -> rd_col=0 gives 8'h41, rd_col=1 gives 8'h42, cursor=2. Blank=0, in_valid=1 -> in_ready=0, no write, cursor unchanged.
- Wrap and control codes:
  - 33 printable bytes 8'h30.. with blank=1 -> cell 0 holds the 33rd byte (8'h50), cursor=1.
  - Then 8'h0D -> cursor=0.
  - Then 8'h08 -> cursor=31, cell 31 = 8'h20.
- Buffer full of 8'h41, send 8'h0C with blank toggling 1/0 every 4 cycles -> busy high for exactly 32 blank=1 cycles plus the pauses. All cells = 8'h20 afterwards; in_ready stays low throughout busy.
- Assert rst_n=0 mid-CLEAR (clr_idx=10) -> busy=0 and all cells 8'h20 immediately, without waiting for a clock edge. Ignored codes 8'h07 and 8'h9F -> accepted (in_ready=1), buffer and cursor unchanged.
